// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: round-robin arbiter sharing one frame-buffer SRAM port between BLA, fill and alpha engines.
module fb_access_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              bla_req,
  input  logic [ADDR_W-1:0] bla_addr,
  input  logic [DATA_W-1:0] bla_wdata,
  output logic              bla_ack,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_wdata,
  output logic              fill_ack,
  input  logic              alpha_req,
  input  logic              alpha_we,
  input  logic [ADDR_W-1:0] alpha_addr,
  input  logic [DATA_W-1:0] alpha_wdata,
  output logic              alpha_ack,
  output logic [DATA_W-1:0] alpha_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              mem_err
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t            state_q;
  logic [1:0]        gnt_q, last_q, gnt_d, p0, p1, p2;
  logic              we_q, abort_q, done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        req;
  assign req = {alpha_req, fill_req, bla_req};
  // search order starts just after the last requester served
  assign p0 = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
  assign p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
  assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
  assign gnt_d = req[p0] ? p0 : req[p1] ? p1 : p2;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          gnt_q   <= gnt_d;
          addr_q  <= gnt_d == 2'd0 ? bla_addr : gnt_d == 2'd1 ? fill_addr : alpha_addr;
          wdata_q <= gnt_d == 2'd0 ? bla_wdata : gnt_d == 2'd1 ? fill_wdata : alpha_wdata;
          we_q    <= gnt_d == 2'd2 ? alpha_we : 1'b1;
          cnt_q   <= '0;
          abort_q <= 1'b0;
          state_q <= ACCESS;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ready) begin
            state_q <= DONE;
            if (!we_q) rdata_q <= mem_rdata;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_q <= DONE;
            abort_q <= 1'b1;
          end
        end
        DONE: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done        = state_q == DONE;
  assign mem_req     = state_q == ACCESS;
  assign mem_we      = mem_req & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = state_q != IDLE;
  assign bla_ack     = done && gnt_q == 2'd0;
  assign fill_ack    = done && gnt_q == 2'd1;
  assign alpha_ack   = done && gnt_q == 2'd2;
  assign mem_err     = done && abort_q;
  assign alpha_rdata = rdata_q;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb_fb_access_arbiter: directed scenarios for the frame-buffer arbiter; inputs driven and outputs sampled on the falling edge.
module tb_fb_access_arbiter;
  logic        clk = 1'b0, n_rst = 1'b0;
  logic        bla_req = 0, fill_req = 0, alpha_req = 0, alpha_we = 0, mem_ready = 0;
  logic [18:0] bla_addr = 0, fill_addr = 0, alpha_addr = 0;
  logic [23:0] bla_wdata = 0, fill_wdata = 0, alpha_wdata = 0, mem_rdata = 0;
  logic        bla_ack, fill_ack, alpha_ack, mem_req, mem_we, busy, mem_err;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata, alpha_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fb_access_arbiter dut (
    .clk(clk), .n_rst(n_rst),
    .bla_req(bla_req), .bla_addr(bla_addr), .bla_wdata(bla_wdata), .bla_ack(bla_ack),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_ack(fill_ack),
    .alpha_req(alpha_req), .alpha_we(alpha_we), .alpha_addr(alpha_addr), .alpha_wdata(alpha_wdata),
    .alpha_ack(alpha_ack), .alpha_rdata(alpha_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .mem_err(mem_err)
  );
  task automatic test_reset;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, mem_we, busy, mem_err} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 0000", {mem_req, mem_we, busy, mem_err}); end
    checks++; if ({alpha_ack, fill_ack, bla_ack} !== 3'b0) begin errors++; $display("FAIL reset_acks: got %b expected 000", {alpha_ack, fill_ack, bla_ack}); end
    checks++; if (mem_addr !== 19'h0 || mem_wdata !== 24'h0) begin errors++; $display("FAIL reset_bus: got addr %h data %h expected 0", mem_addr, mem_wdata); end
    checks++; if (alpha_rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", alpha_rdata); end
    n_rst = 1'b1;
  endtask
  task automatic test_contention;
    logic [18:0] addrs [3];
    logic [23:0] datas [3];
    addrs = '{19'h00100, 19'h00200, 19'h00300};
    datas = '{24'h0000AA, 24'h00BB00, 24'hCC0000};
    bla_addr = addrs[0]; fill_addr = addrs[1]; alpha_addr = addrs[2];
    bla_wdata = datas[0]; fill_wdata = datas[1]; alpha_wdata = datas[2];
    alpha_we = 1'b1;
    bla_req = 1; fill_req = 1; alpha_req = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_addr !== addrs[k % 3]) begin errors++; $display("FAIL rr_grant%0d: got req %b addr %h expected 1 %h", k, mem_req, mem_addr, addrs[k % 3]); end
      checks++; if (mem_we !== 1'b1 || mem_wdata !== datas[k % 3]) begin errors++; $display("FAIL rr_wdata%0d: got we %b data %h expected 1 %h", k, mem_we, mem_wdata, datas[k % 3]); end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      checks++; if ({alpha_ack, fill_ack, bla_ack} !== 3'b001 << (k % 3)) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", k, {alpha_ack, fill_ack, bla_ack}, 3'b001 << (k % 3)); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || {alpha_ack, fill_ack, bla_ack} !== 3'b0) begin errors++; $display("FAIL rr_idle%0d: got busy %b acks %b expected 0 000", k, busy, {alpha_ack, fill_ack, bla_ack}); end
    end
    bla_req = 0; fill_req = 0; alpha_req = 0;
    @(negedge clk);
  endtask
  task automatic test_single_bla;
    bla_addr = 19'h01234; bla_wdata = 24'hFF0000; bla_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || bla_ack !== 1'b0) begin errors++; $display("FAIL bla_access%0d: got req %b we %b ack %b expected 1 1 0", c, mem_req, mem_we, bla_ack); end
    end
    checks++; if (mem_addr !== 19'h01234 || mem_wdata !== 24'hFF0000) begin errors++; $display("FAIL bla_bus: got %h %h expected 01234 ff0000", mem_addr, mem_wdata); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    checks++; if ({mem_req, bla_ack, fill_ack, alpha_ack, mem_err} !== 5'b01000) begin errors++; $display("FAIL bla_done: got %b expected 01000", {mem_req, bla_ack, fill_ack, alpha_ack, mem_err}); end
    bla_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, bla_ack, busy} !== 3'b000) begin errors++; $display("FAIL bla_after: got %b expected 000", {mem_req, bla_ack, busy}); end
  endtask
  task automatic test_alpha_rmw;
    alpha_addr = 19'h00010; alpha_we = 1'b0; alpha_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'h00010) begin errors++; $display("FAIL rmw_read: got req %b we %b addr %h expected 1 0 00010", mem_req, mem_we, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 24'h123456;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 24'hABCDEF; alpha_req = 1'b0;
    checks++; if (alpha_ack !== 1'b1 || alpha_rdata !== 24'h123456) begin errors++; $display("FAIL rmw_rdata: got ack %b data %h expected 1 123456", alpha_ack, alpha_rdata); end
    @(negedge clk);
    alpha_we = 1'b1; alpha_wdata = 24'h0F0F0F; alpha_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 24'h0F0F0F) begin errors++; $display("FAIL rmw_write: got req %b we %b data %h expected 1 1 0f0f0f", mem_req, mem_we, mem_wdata); end
    mem_ready = 1'b1; mem_rdata = 24'h654321;
    @(negedge clk);
    mem_ready = 1'b0; alpha_req = 1'b0;
    checks++; if (alpha_ack !== 1'b1 || alpha_rdata !== 24'h123456) begin errors++; $display("FAIL rmw_hold: got ack %b data %h expected 1 123456", alpha_ack, alpha_rdata); end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 24'hDEAD00;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || alpha_ack !== 1'b0 || alpha_rdata !== 24'h123456) begin errors++; $display("FAIL stray_ready: got busy %b ack %b data %h expected 0 0 123456", busy, alpha_ack, alpha_rdata); end
  endtask
  task automatic test_watchdog;
    fill_addr = 19'h05555; fill_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || fill_ack !== 1'b0 || mem_err !== 1'b0) begin errors++; $display("FAIL wd_wait%0d: got req %b ack %b err %b expected 1 0 0", c, mem_req, fill_ack, mem_err); end
    end
    @(negedge clk);
    fill_req = 1'b0;
    checks++; if ({mem_req, fill_ack, mem_err} !== 3'b011) begin errors++; $display("FAIL wd_abort: got %b expected 011", {mem_req, fill_ack, mem_err}); end
    @(negedge clk);
    checks++; if ({fill_ack, mem_err, busy} !== 3'b000) begin errors++; $display("FAIL wd_after: got %b expected 000", {fill_ack, mem_err, busy}); end
  endtask
  task automatic test_reset_mid_access;
    bla_addr = 19'h00ABC; bla_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_pre: got req %b expected 1", mem_req); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: got req %b busy %b expected 0 0", mem_req, busy); end
    bla_addr = 19'h00777;
    @(negedge clk);
    checks++; if (bla_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL mid_noack: got ack %b req %b expected 0 0", bla_ack, mem_req); end
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 19'h00777) begin errors++; $display("FAIL mid_fresh: got req %b addr %h expected 1 00777", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; bla_req = 1'b0;
    checks++; if (bla_ack !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL mid_ack: got ack %b err %b expected 1 0", bla_ack, mem_err); end
    @(negedge clk);
  endtask
  initial begin
    test_reset;
    test_contention;
    test_single_bla;
    test_alpha_rmw;
    test_watchdog;
    test_reset_mid_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
